// File: rtl/conv_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_sched_pkg
//  Description : Shared types and helpers for the tiled-convolution loop-nest
//                sequencer: FSM state encoding, default layer geometry,
//                derived input-map dimensions and counter width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default layer geometry
  localparam int DEF_M  = 7;
  localparam int DEF_N  = 3;
  localparam int DEF_R  = 10;
  localparam int DEF_C  = 10;
  localparam int DEF_K  = 3;
  localparam int DEF_TR = 2;
  localparam int DEF_TC = 2;
  localparam int DEF_S  = 1;
  localparam int DEF_AW = 16;

  // Input-map height/width needed to produce r x c outputs
  function automatic int calc_ih(input int r, input int k, input int s);
    return (r - 1) * s + k;
  endfunction

  function automatic int calc_iw(input int c, input int k, input int s);
    return (c - 1) * s + k;
  endfunction

  function automatic int calc_total(input int m, input int n, input int r,
                                    input int c, input int k);
    return m * r * c * n * k * k;
  endfunction

  localparam int IH         = calc_ih(DEF_R, DEF_K, DEF_S);
  localparam int IW         = calc_iw(DEF_C, DEF_K, DEF_S);
  localparam int TOTAL_CMDS = calc_total(DEF_M, DEF_N, DEF_R, DEF_C, DEF_K);

  // Bits needed for a counter holding values 0..n-1
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Extent of a tile clipped against the remaining array size
  function automatic logic [31:0] clip_lim(input logic [31:0] remain,
                                           input logic [31:0] tile);
    return (remain < tile) ? remain : tile;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_loop_counter.sv
`default_nettype none
// ============================================================================
//  Module      : conv_loop_counter
//  Description : One level of the loop nest. Advances by STEP when en is high
//                and wraps to zero once the next value would reach the limit.
//                The limit is either the LIMIT parameter or, with DYN=1, the
//                lim input (used for clipped edge tiles).
//  Ports       : clk, rst (async, active-high), en (advance), clr (force 0),
//                lim (dynamic limit), nxt (value after this edge),
//                wrap (level wraps in this cycle; carry to the outer level)
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_loop_counter #(
  parameter int LIMIT = 2,
  parameter int STEP  = 1,
  parameter int DYN   = 0,
  parameter int W     = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [31:0]   lim,
  output logic [W-1:0]  nxt,
  output logic          wrap
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [31:0]  sum;
  logic [31:0]  lim_eff;

  always_comb begin
    lim_eff = (DYN != 0) ? lim : 32'(LIMIT);
    sum     = 32'(cnt_q) + 32'(STEP);
    wrap    = en && (sum >= lim_eff);
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : sum[W-1:0];
    end
  end

  // The top builds registered addresses from the post-edge index values
  assign nxt = cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : conv_tile_scheduler
//  Description : Loop-nest sequencer for the tiled convolution datapath.
//                Walks to / row tile / col tile / in-tile row / in-tile col /
//                ti / ki / kj and issues one PE command per accepted cycle.
//  Ports       : clk, rst (async, active-high), start, abort,
//                busy, done, cmd_valid, cmd_ready,
//                wt_addr, in_addr, out_addr, acc_clr, acc_wr
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_tile_scheduler
  import conv_sched_pkg::*;
#(
  parameter int M  = DEF_M,
  parameter int N  = DEF_N,
  parameter int R  = DEF_R,
  parameter int C  = DEF_C,
  parameter int K  = DEF_K,
  parameter int TR = DEF_TR,
  parameter int TC = DEF_TC,
  parameter int S  = DEF_S,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [AW-1:0] wt_addr,
  output logic [AW-1:0] in_addr,
  output logic [AW-1:0] out_addr,
  output logic          acc_clr,
  output logic          acc_wr
);

  localparam int L_IH  = calc_ih(R, K, S);
  localparam int L_IW  = calc_iw(C, K, S);
  localparam int W_TO  = cnt_w(M);
  localparam int W_RB  = cnt_w(R);
  localparam int W_CB  = cnt_w(C);
  localparam int W_TRR = cnt_w(TR);
  localparam int W_TCC = cnt_w(TC);
  localparam int W_TI  = cnt_w(N);
  localparam int W_K   = cnt_w(K);

  localparam longint WT_MAX   = longint'(M) * N * K * K - 1;
  localparam longint IN_MAX   = longint'(N) * L_IH * L_IW - 1;
  localparam longint OUT_MAX  = longint'(M) * R * C - 1;
  localparam longint ADDR_LIM = longint'(1) << AW;

  if (WT_MAX >= ADDR_LIM || IN_MAX >= ADDR_LIM || OUT_MAX >= ADDR_LIM) begin : g_addr_range_err
    $error("conv_tile_scheduler: address range exceeds AW bits");
  end

  state_e          state_q, state_d;
  logic            busy_q, busy_d, done_q, done_d, cmd_valid_q, cmd_valid_d;
  logic [AW-1:0]   wt_addr_q, wt_addr_d, in_addr_q, in_addr_d, out_addr_q, out_addr_d;
  logic            acc_clr_q, acc_clr_d, acc_wr_q, acc_wr_d;
  logic [31:0]     trr_lim_q, trr_lim_d, tcc_lim_q, tcc_lim_d;

  logic            hs, adv, clr_idx, last;
  logic [W_TO-1:0]  to_n;
  logic [W_RB-1:0]  rb_n;
  logic [W_CB-1:0]  cb_n;
  logic [W_TRR-1:0] trr_n;
  logic [W_TCC-1:0] tcc_n;
  logic [W_TI-1:0]  ti_n;
  logic [W_K-1:0]   ki_n, kj_n;
  logic to_wrap, rb_wrap, cb_wrap, trr_wrap, tcc_wrap, ti_wrap, ki_wrap, kj_wrap;
  logic [31:0]     r_full, c_full;

  assign hs      = cmd_valid_q && cmd_ready;
  // abort beats a coincident handshake: indices clear instead of advancing
  assign adv     = hs && !abort;
  assign clr_idx = abort || (state_q != RUN);
  assign last    = to_wrap;

  // Carry chain, innermost (kj) to outermost (to)
  conv_loop_counter #(.LIMIT(K),  .STEP(1),  .DYN(0), .W(W_K))   u_kj  (.clk(clk), .rst(rst), .en(adv),      .clr(clr_idx), .lim(32'(K)),  .nxt(kj_n),  .wrap(kj_wrap));
  conv_loop_counter #(.LIMIT(K),  .STEP(1),  .DYN(0), .W(W_K))   u_ki  (.clk(clk), .rst(rst), .en(kj_wrap),  .clr(clr_idx), .lim(32'(K)),  .nxt(ki_n),  .wrap(ki_wrap));
  conv_loop_counter #(.LIMIT(N),  .STEP(1),  .DYN(0), .W(W_TI))  u_ti  (.clk(clk), .rst(rst), .en(ki_wrap),  .clr(clr_idx), .lim(32'(N)),  .nxt(ti_n),  .wrap(ti_wrap));
  conv_loop_counter #(.LIMIT(TC), .STEP(1),  .DYN(1), .W(W_TCC)) u_tcc (.clk(clk), .rst(rst), .en(ti_wrap),  .clr(clr_idx), .lim(tcc_lim_q), .nxt(tcc_n), .wrap(tcc_wrap));
  conv_loop_counter #(.LIMIT(TR), .STEP(1),  .DYN(1), .W(W_TRR)) u_trr (.clk(clk), .rst(rst), .en(tcc_wrap), .clr(clr_idx), .lim(trr_lim_q), .nxt(trr_n), .wrap(trr_wrap));
  conv_loop_counter #(.LIMIT(C),  .STEP(TC), .DYN(0), .W(W_CB))  u_cb  (.clk(clk), .rst(rst), .en(trr_wrap), .clr(clr_idx), .lim(32'(C)),  .nxt(cb_n),  .wrap(cb_wrap));
  conv_loop_counter #(.LIMIT(R),  .STEP(TR), .DYN(0), .W(W_RB))  u_rb  (.clk(clk), .rst(rst), .en(cb_wrap),  .clr(clr_idx), .lim(32'(R)),  .nxt(rb_n),  .wrap(rb_wrap));
  conv_loop_counter #(.LIMIT(M),  .STEP(1),  .DYN(0), .W(W_TO))  u_to  (.clk(clk), .rst(rst), .en(rb_wrap),  .clr(clr_idx), .lim(32'(M)),  .nxt(to_n),  .wrap(to_wrap));

  // Clipped in-tile limits are registered from the next tile base, so they
  // always describe the tile the counters currently sit in and no
  // combinational loop forms through the base counters.
  always_comb begin
    trr_lim_d = clip_lim(32'(R) - 32'(rb_n), 32'(TR));
    tcc_lim_d = clip_lim(32'(C) - 32'(cb_n), 32'(TC));
  end

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d     = RUN;
          cmd_valid_d = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hs && last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cmd_valid_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Command fields for the indices that will be current after this edge
  always_comb begin
    r_full     = 32'(rb_n) + 32'(trr_n);
    c_full     = 32'(cb_n) + 32'(tcc_n);
    wt_addr_d  = '0;
    in_addr_d  = '0;
    out_addr_d = '0;
    acc_clr_d  = 1'b0;
    acc_wr_d   = 1'b0;
    if (cmd_valid_d) begin
      wt_addr_d  = AW'(((32'(to_n) * 32'(N) + 32'(ti_n)) * 32'(K) + 32'(ki_n)) * 32'(K) + 32'(kj_n));
      in_addr_d  = AW'((32'(ti_n) * 32'(L_IH) + 32'(S) * r_full + 32'(ki_n)) * 32'(L_IW)
                       + 32'(S) * c_full + 32'(kj_n));
      out_addr_d = AW'((32'(to_n) * 32'(R) + r_full) * 32'(C) + c_full);
      acc_clr_d  = (ti_n == '0) && (ki_n == '0) && (kj_n == '0);
      acc_wr_d   = (32'(ti_n) == 32'(N - 1)) && (32'(ki_n) == 32'(K - 1)) && (32'(kj_n) == 32'(K - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      wt_addr_q   <= '0;
      in_addr_q   <= '0;
      out_addr_q  <= '0;
      acc_clr_q   <= 1'b0;
      acc_wr_q    <= 1'b0;
      trr_lim_q   <= clip_lim(32'(R), 32'(TR));
      tcc_lim_q   <= clip_lim(32'(C), 32'(TC));
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_valid_q <= cmd_valid_d;
      wt_addr_q   <= wt_addr_d;
      in_addr_q   <= in_addr_d;
      out_addr_q  <= out_addr_d;
      acc_clr_q   <= acc_clr_d;
      acc_wr_q    <= acc_wr_d;
      trr_lim_q   <= trr_lim_d;
      tcc_lim_q   <= tcc_lim_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_valid = cmd_valid_q;
  assign wt_addr   = wt_addr_q;
  assign in_addr   = in_addr_q;
  assign out_addr  = out_addr_q;
  assign acc_clr   = acc_clr_q;
  assign acc_wr    = acc_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_tile_scheduler
//  Description : Self-checking bench. Instance 0 uses a small 3x3 layer with
//                2x2 kernel, instance 1 uses the default geometry. A loop-nest
//                reference model builds the expected command list for each.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_tile_scheduler;

  typedef struct {
    int unsigned wt;
    int unsigned inp;
    int unsigned outp;
    bit          clr;
    bit          wr;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst[2], start[2], abort[2], cmd_ready[2];
  logic        busy[2], done[2], cmd_valid[2], acc_clr[2], acc_wr[2];
  logic [15:0] wt_addr[2], in_addr[2], out_addr[2];

  always #5 clk = ~clk;

  conv_tile_scheduler #(.M(1), .N(1), .R(3), .C(3), .K(2), .TR(2), .TC(2), .S(1), .AW(16)) u_small (
    .clk(clk), .rst(rst[0]), .start(start[0]), .abort(abort[0]), .busy(busy[0]), .done(done[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .wt_addr(wt_addr[0]), .in_addr(in_addr[0]),
    .out_addr(out_addr[0]), .acc_clr(acc_clr[0]), .acc_wr(acc_wr[0]));

  conv_tile_scheduler #(.M(7), .N(3), .R(10), .C(10), .K(3), .TR(2), .TC(2), .S(1), .AW(16)) u_dflt (
    .clk(clk), .rst(rst[1]), .start(start[1]), .abort(abort[1]), .busy(busy[1]), .done(done[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .wt_addr(wt_addr[1]), .in_addr(in_addr[1]),
    .out_addr(out_addr[1]), .acc_clr(acc_clr[1]), .acc_wr(acc_wr[1]));

  cmd_t exp0[$], exp1[$];
  int   n_pass = 0, n_total = 0;
  bit   m_run[2], m_done[2];
  int   m_pos[2];
  int   hs_cnt[2], clr_cnt[2], wr_cnt[2], done_cnt[2];
  int   max_wt[2], max_in[2], max_out[2];
  int   rmode[2];
  int   cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: walk the loop nest directly, clipping edge tiles
  task automatic build(input int d, input int mm, input int nn, input int rr, input int cc,
                       input int kk, input int tr, input int tc, input int s);
    int ih, iw, r, c;
    cmd_t e;
    ih = (rr - 1) * s + kk;
    iw = (cc - 1) * s + kk;
    for (int to = 0; to < mm; to++)
      for (int rb = 0; rb < rr; rb += tr)
        for (int cb = 0; cb < cc; cb += tc)
          for (int trr = 0; trr < ((tr < rr - rb) ? tr : rr - rb); trr++)
            for (int tcc = 0; tcc < ((tc < cc - cb) ? tc : cc - cb); tcc++)
              for (int ti = 0; ti < nn; ti++)
                for (int ki = 0; ki < kk; ki++)
                  for (int kj = 0; kj < kk; kj++) begin
                    r      = rb + trr;
                    c      = cb + tcc;
                    e.wt   = ((to * nn + ti) * kk + ki) * kk + kj;
                    e.inp  = (ti * ih + s * r + ki) * iw + s * c + kj;
                    e.outp = (to * rr + r) * cc + c;
                    e.clr  = (ti == 0 && ki == 0 && kj == 0);
                    e.wr   = (ti == nn - 1 && ki == kk - 1 && kj == kk - 1);
                    if (d == 0) exp0.push_back(e);
                    else        exp1.push_back(e);
                  end
  endtask

  function automatic int exp_size(input int d);
    return (d == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic cmd_t get_exp(input int d, input int p);
    return (d == 0) ? exp0[p] : exp1[p];
  endfunction

  // Pass-level behaviour: a pass runs until every command has been accepted,
  // done is high for the single cycle that follows, abort/rst drop the pass.
  task automatic model_step(input int d);
    if (rst[d]) begin
      m_run[d] = 0; m_done[d] = 0; m_pos[d] = 0;
    end else if (m_run[d]) begin
      if (abort[d]) begin
        m_run[d] = 0; m_pos[d] = 0;
      end else if (cmd_ready[d]) begin
        m_pos[d]++;
        if (m_pos[d] == exp_size(d)) begin
          m_run[d] = 0; m_pos[d] = 0; m_done[d] = 1;
        end
      end
    end else if (m_done[d]) begin
      m_done[d] = 0;
    end else if (start[d] && !abort[d]) begin
      m_run[d] = 1;
    end
  endtask

  always @(posedge clk or posedge rst[0]) model_step(0);
  always @(posedge clk or posedge rst[1]) model_step(1);

  task automatic compare(input int d);
    cmd_t e;
    if (rst[d]) return;
    check($sformatf("d%0d cmd_valid", d), int'(cmd_valid[d]), int'(m_run[d]));
    check($sformatf("d%0d busy", d), int'(busy[d]), int'(m_run[d] || m_done[d]));
    check($sformatf("d%0d done", d), int'(done[d]), int'(m_done[d]));
    if (m_run[d] && m_pos[d] < exp_size(d)) begin
      e = get_exp(d, m_pos[d]);
      check($sformatf("d%0d wt_addr cmd%0d", d, m_pos[d]), int'(wt_addr[d]), int'(e.wt));
      check($sformatf("d%0d in_addr cmd%0d", d, m_pos[d]), int'(in_addr[d]), int'(e.inp));
      check($sformatf("d%0d out_addr cmd%0d", d, m_pos[d]), int'(out_addr[d]), int'(e.outp));
      check($sformatf("d%0d acc_clr cmd%0d", d, m_pos[d]), int'(acc_clr[d]), int'(e.clr));
      check($sformatf("d%0d acc_wr cmd%0d", d, m_pos[d]), int'(acc_wr[d]), int'(e.wr));
    end
    if (cmd_valid[d] && cmd_ready[d]) begin
      hs_cnt[d]++;
      if (acc_clr[d]) clr_cnt[d]++;
      if (acc_wr[d])  wr_cnt[d]++;
      if (int'(wt_addr[d])  > max_wt[d])  max_wt[d]  = int'(wt_addr[d]);
      if (int'(in_addr[d])  > max_in[d])  max_in[d]  = int'(in_addr[d]);
      if (int'(out_addr[d]) > max_out[d]) max_out[d] = int'(out_addr[d]);
    end
    if (done[d]) done_cnt[d]++;
  endtask

  always @(negedge clk) begin
    compare(0);
    compare(1);
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      case (rmode[d])
        0:       cmd_ready[d] = 1'b1;
        1:       cmd_ready[d] = 1'($urandom_range(0, 1));
        default: cmd_ready[d] = (cyc % 3 == 0);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    int n = 0;
    while (done[d] !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("d%0d done within budget", d), int'(done[d] === 1'b1), 1);
  endtask

  task automatic clear_stats(input int d);
    hs_cnt[d] = 0; clr_cnt[d] = 0; wr_cnt[d] = 0; done_cnt[d] = 0;
    max_wt[d] = 0; max_in[d] = 0; max_out[d] = 0;
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    check($sformatf("d%0d %s cmd_valid", d, tag), int'(cmd_valid[d]), 0);
    check($sformatf("d%0d %s busy", d, tag), int'(busy[d]), 0);
    check($sformatf("d%0d %s done", d, tag), int'(done[d]), 0);
    check($sformatf("d%0d %s wt_addr", d, tag), int'(wt_addr[d]), 0);
    check($sformatf("d%0d %s in_addr", d, tag), int'(in_addr[d]), 0);
    check($sformatf("d%0d %s out_addr", d, tag), int'(out_addr[d]), 0);
    check($sformatf("d%0d %s acc_clr", d, tag), int'(acc_clr[d]), 0);
    check($sformatf("d%0d %s acc_wr", d, tag), int'(acc_wr[d]), 0);
  endtask

  initial begin
    int pin_out[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 3};
    int n;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; abort[d] = 1'b0; cmd_ready[d] = 1'b1; rmode[d] = 0;
      clear_stats(d);
    end
    build(0, 1, 1, 3, 3, 2, 2, 2, 1);
    build(1, 7, 3, 10, 10, 3, 2, 2, 1);

    // Hand-derived anchors for the reference model itself
    check("model small count", exp0.size(), 36);
    check("model default count", exp1.size(), 18900);
    for (int i = 0; i < 9; i++) check($sformatf("model small out_addr[%0d]", i), int'(exp0[i].outp), pin_out[i]);
    check("model clipped tile first pixel", int'(exp0[16].outp), 2);
    check("model clipped tile second pixel", int'(exp0[20].outp), 5);
    check("model last row tile", int'(exp0[24].outp), 6);
    check("model default last wt", int'(exp1[18899].wt), 188);
    check("model default last in", int'(exp1[18899].inp), 431);
    check("model default last out", int'(exp1[18899].outp), 699);

    repeat (3) @(posedge clk);
    #3;
    check_idle_outputs(0, "reset");
    check_idle_outputs(1, "reset");
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();

    // Small layer, always ready
    clear_stats(0);
    pulse_start(0);
    wait_done(0, 200);
    check("small ready=1 cmd_valid at done", int'(cmd_valid[0]), 0);
    check("small ready=1 busy at done", int'(busy[0]), 1);
    repeat (3) tick();
    check("small ready=1 handshakes", hs_cnt[0], 36);
    check("small ready=1 done pulses", done_cnt[0], 1);
    check("small ready=1 busy after", int'(busy[0]), 0);

    // Small layer, random backpressure
    rmode[0] = 1;
    clear_stats(0);
    pulse_start(0);
    wait_done(0, 2000);
    repeat (3) tick();
    check("small random handshakes", hs_cnt[0], 36);
    check("small random done pulses", done_cnt[0], 1);

    // Default layer, always ready
    clear_stats(1);
    pulse_start(1);
    wait_done(1, 20000);
    repeat (3) tick();
    check("default handshakes", hs_cnt[1], 18900);
    check("default acc_clr count", clr_cnt[1], 700);
    check("default acc_wr count", wr_cnt[1], 700);
    check("default max wt_addr", max_wt[1], 188);
    check("default max out_addr", max_out[1], 699);
    check("default max in_addr", max_in[1], 431);
    check("default done pulses", done_cnt[1], 1);

    // Extra starts while busy are ignored
    rmode[0] = 2;
    clear_stats(0);
    pulse_start(0);
    repeat (4) tick();
    pulse_start(0);
    repeat (34) tick();
    pulse_start(0);
    wait_done(0, 1000);
    repeat (5) tick();
    check("start-while-busy handshakes", hs_cnt[0], 36);
    check("start-while-busy done pulses", done_cnt[0], 1);
    check("start-while-busy busy after", int'(busy[0]), 0);

    // Abort while the 10th command is presented
    rmode[0] = 0;
    repeat (2) tick();
    clear_stats(0);
    pulse_start(0);
    n = 0;
    while (m_pos[0] != 9 && n < 100) begin
      tick();
      n++;
    end
    check("abort reached 10th command", m_pos[0], 9);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("abort cmd_valid", int'(cmd_valid[0]), 0);
    check("abort busy", int'(busy[0]), 0);
    check("abort done", int'(done[0]), 0);
    repeat (5) tick();
    check("abort no done pulse", done_cnt[0], 0);
    clear_stats(0);
    pulse_start(0);
    check("restart wt_addr", int'(wt_addr[0]), 0);
    check("restart in_addr", int'(in_addr[0]), 0);
    check("restart out_addr", int'(out_addr[0]), 0);
    check("restart acc_clr", int'(acc_clr[0]), 1);
    check("restart cmd_valid", int'(cmd_valid[0]), 1);
    wait_done(0, 200);
    repeat (3) tick();
    check("restart handshakes", hs_cnt[0], 36);

    // Asynchronous reset mid-pass
    clear_stats(0);
    pulse_start(0);
    repeat (7) tick();
    #2;
    rst[0] = 1'b1;
    #1;
    check_idle_outputs(0, "async rst");
    @(negedge clk);
    #2;
    rst[0] = 1'b0;
    tick();
    check("async rst no done pulse", done_cnt[0], 0);
    clear_stats(0);
    pulse_start(0);
    wait_done(0, 200);
    repeat (3) tick();
    check("post-reset handshakes", hs_cnt[0], 36);
    check("post-reset done pulses", done_cnt[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
